// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode, funct and datapath-select encodings
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   function automatic logic is_zeroext_op(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// rtl/mips_mc_controller_if.sv - controller <-> datapath/memory signal bundle
interface mips_mc_controller_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             zero;
   logic             memready;
   logic             memreq;
   logic             memwrite;
   logic             IorD;
   logic             IRwrite;
   logic             memtoreg;
   logic             pcEn;
   logic             regwrite;
   logic             regdst;
   logic             alusrcA;
   logic             zeroext;
   logic [2:0]       alucontrol;
   logic [1:0]       alusrcB;
   logic [1:0]       pcsrc;
   logic             illegal;
   logic [CNT_W-1:0] instret;

   modport master (
      input  op, funct, zero, memready,
      output memreq, memwrite, IorD, IRwrite, memtoreg, pcEn, regwrite,
             regdst, alusrcA, zeroext, alucontrol, alusrcB, pcsrc,
             illegal, instret
   );

   modport slave (
      output op, funct, zero, memready,
      input  memreq, memwrite, IorD, IRwrite, memtoreg, pcEn, regwrite,
             regdst, alusrcA, zeroext, alucontrol, alusrcB, pcsrc,
             illegal, instret
   );
endinterface

// File: rtl/mips_mc_controller_alu_decoder.sv
// rtl/mips_mc_controller_alu_decoder.sv - R-type funct to alucontrol map with validity flag
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       funct_ok
);

   always_comb begin
      alucontrol = ALU_ADD;
      funct_ok   = 1'b1;
      case (funct)
         F_ADD:   alucontrol = ALU_ADD;
         F_SUB:   alucontrol = ALU_SUB;
         F_AND:   alucontrol = ALU_AND;
         F_OR:    alucontrol = ALU_OR;
         F_SLT:   alucontrol = ALU_SLT;
         default: funct_ok   = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with memready-stalled memory accesses
module mips_mc_controller
   import mips_pkg::*;
#(
   parameter bit EXT_OPS = 1'b1,
   parameter int CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   mips_mc_controller_if.master bus
);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       funct_ctl;
   logic             funct_ok;

   logic       memreq_c, memwrite_c, irwrite_c, pcen_c, regwrite_c, illegal_c;
   logic       iord, memtoreg, regdst, alusrca, zeroext, retire;
   logic [2:0] aluctl;
   logic [1:0] srcb, pcsrc;

   alu_decoder u_alu_decoder (
      .funct      (bus.funct),
      .alucontrol (funct_ctl),
      .funct_ok   (funct_ok)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      memreq_c   = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      pcen_c     = 1'b0;
      regwrite_c = 1'b0;
      illegal_c  = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      zeroext    = 1'b0;
      retire     = 1'b0;
      aluctl     = 3'b000;
      srcb       = SRCB_B;
      pcsrc      = PC_ALU;
      case (state)
         S_FETCH: begin
            memreq_c = 1'b1;
            srcb     = SRCB_FOUR;
            aluctl   = ALU_ADD;
            if (bus.memready) begin
               irwrite_c  = 1'b1;
               pcen_c     = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // branch target is computed here so BRANCH can take it from aluout
            srcb       = SRCB_IMMSH;
            aluctl     = ALU_ADD;
            state_next = S_FETCH;
            case (bus.op)
               OP_LW, OP_SW:               state_next = S_MEMADR;
               OP_RTYPE: if (funct_ok)     state_next = S_EXEC;
               OP_BEQ:                     state_next = S_BRANCH;
               OP_BNE:   if (EXT_OPS)      state_next = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI:
                         if (EXT_OPS)      state_next = S_IEXEC;
               OP_J:     if (EXT_OPS)      state_next = S_JUMP;
               default:                    state_next = S_FETCH;
            endcase
            illegal_c = (state_next == S_FETCH);
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            srcb       = SRCB_IMM;
            aluctl     = ALU_ADD;
            state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            memreq_c = 1'b1;
            iord     = 1'b1;
            if (bus.memready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite_c = 1'b1;
            memtoreg   = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWR: begin
            memreq_c   = 1'b1;
            memwrite_c = 1'b1;
            iord       = 1'b1;
            if (bus.memready) begin
               retire     = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXEC: begin
            alusrca    = 1'b1;
            srcb       = SRCB_B;
            aluctl     = funct_ctl;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            regdst     = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            srcb       = SRCB_B;
            aluctl     = ALU_SUB;
            pcsrc      = PC_ALUOUT;
            pcen_c     = ((bus.op == OP_BEQ) &&  bus.zero) ||
                         ((bus.op == OP_BNE) && !bus.zero);
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_IEXEC: begin
            alusrca = 1'b1;
            srcb    = SRCB_IMM;
            zeroext = is_zeroext_op(bus.op);
            case (bus.op)
               OP_ANDI: aluctl = ALU_AND;
               OP_ORI:  aluctl = ALU_OR;
               default: aluctl = ALU_ADD;
            endcase
            state_next = S_IWB;
         end
         S_IWB: begin
            // the instruction register is stable, so recomputing keeps zeroext unchanged
            regwrite_c = 1'b1;
            zeroext    = is_zeroext_op(bus.op);
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_JUMP: begin
            pcsrc      = PC_JUMP;
            pcen_c     = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       cnt <= '0;
      else if (retire) cnt <= cnt + CNT_W'(1);
   end

   // strobes are masked while reset is held so no access or write leaks out
   assign bus.memreq     = memreq_c   & ~reset;
   assign bus.memwrite   = memwrite_c & ~reset;
   assign bus.IRwrite    = irwrite_c  & ~reset;
   assign bus.pcEn       = pcen_c     & ~reset;
   assign bus.regwrite   = regwrite_c & ~reset;
   assign bus.illegal    = illegal_c  & ~reset;
   assign bus.IorD       = iord;
   assign bus.memtoreg   = memtoreg;
   assign bus.regdst     = regdst;
   assign bus.alusrcA    = alusrca;
   assign bus.zeroext    = zeroext;
   assign bus.alucontrol = aluctl;
   assign bus.alusrcB    = srcb;
   assign bus.pcsrc      = pcsrc;
   assign bus.instret    = cnt;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - scoreboard bench for mips_mc_controller
module tb_mips_mc_controller;

   typedef struct packed {
      logic       memreq, memwrite, iord, irwrite, memtoreg, pcen;
      logic       regwrite, regdst, alusrca, zeroext;
      logic [2:0] alucontrol;
      logic [1:0] alusrcb, pcsrc;
      logic       illegal;
   } ctl_t;

   typedef struct {
      string tag;
      ctl_t  v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'b0, funct = 6'b0;
   logic       zero = 1'b0, mr = 1'b0;
   int         sel = 0;
   int         n_cmp = 0, n_bad = 0;
   int         exp_cnt [3] = '{0, 0, 0};
   exp_t       sbq [$];

   always #5 clk = ~clk;

   mips_mc_controller_if #(.CNT_W(32)) if_main ();
   mips_mc_controller_if #(.CNT_W(32)) if_noext ();
   mips_mc_controller_if #(.CNT_W(4))  if_w4 ();

   mips_mc_controller #(.EXT_OPS(1'b1), .CNT_W(32)) u_main  (.clk(clk), .reset(rst), .bus(if_main));
   mips_mc_controller #(.EXT_OPS(1'b0), .CNT_W(32)) u_noext (.clk(clk), .reset(rst), .bus(if_noext));
   mips_mc_controller #(.EXT_OPS(1'b1), .CNT_W(4))  u_w4    (.clk(clk), .reset(rst), .bus(if_w4));

   assign if_main.op  = op;  assign if_main.funct  = funct; assign if_main.zero  = zero;
   assign if_noext.op = op;  assign if_noext.funct = funct; assign if_noext.zero = zero;
   assign if_w4.op    = op;  assign if_w4.funct    = funct; assign if_w4.zero    = zero;
   assign if_main.memready  = mr & (sel == 0);
   assign if_noext.memready = mr & (sel == 1);
   assign if_w4.memready    = mr & (sel == 2);

   ctl_t obs0, obs1, obs2, obs;
   assign obs0 = {if_main.memreq, if_main.memwrite, if_main.IorD, if_main.IRwrite, if_main.memtoreg,
                  if_main.pcEn, if_main.regwrite, if_main.regdst, if_main.alusrcA, if_main.zeroext,
                  if_main.alucontrol, if_main.alusrcB, if_main.pcsrc, if_main.illegal};
   assign obs1 = {if_noext.memreq, if_noext.memwrite, if_noext.IorD, if_noext.IRwrite, if_noext.memtoreg,
                  if_noext.pcEn, if_noext.regwrite, if_noext.regdst, if_noext.alusrcA, if_noext.zeroext,
                  if_noext.alucontrol, if_noext.alusrcB, if_noext.pcsrc, if_noext.illegal};
   assign obs2 = {if_w4.memreq, if_w4.memwrite, if_w4.IorD, if_w4.IRwrite, if_w4.memtoreg,
                  if_w4.pcEn, if_w4.regwrite, if_w4.regdst, if_w4.alusrcA, if_w4.zeroext,
                  if_w4.alucontrol, if_w4.alusrcB, if_w4.pcsrc, if_w4.illegal};
   assign obs  = (sel == 0) ? obs0 : (sel == 1) ? obs1 : obs2;

   logic [31:0] cnt_obs;
   assign cnt_obs = (sel == 0) ? if_main.instret : (sel == 1) ? if_noext.instret : {28'b0, if_w4.instret};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check_eq(e.tag, {13'b0, obs}, {13'b0, e.v});
      end
   end

   // expected per-state control vectors
   function automatic ctl_t c_fetch(input logic m);
      ctl_t c = '0; c.memreq = 1; c.irwrite = m; c.pcen = m; c.alusrcb = 2'b01; c.alucontrol = 3'b010; return c;
   endfunction
   function automatic ctl_t c_decode(input logic ill);
      ctl_t c = '0; c.alusrcb = 2'b11; c.alucontrol = 3'b010; c.illegal = ill; return c;
   endfunction
   function automatic ctl_t c_memadr();
      ctl_t c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; return c;
   endfunction
   function automatic ctl_t c_memrd();
      ctl_t c = '0; c.memreq = 1; c.iord = 1; return c;
   endfunction
   function automatic ctl_t c_memwb();
      ctl_t c = '0; c.regwrite = 1; c.memtoreg = 1; return c;
   endfunction
   function automatic ctl_t c_memwr();
      ctl_t c = '0; c.memreq = 1; c.memwrite = 1; c.iord = 1; return c;
   endfunction
   function automatic ctl_t c_exec(input logic [2:0] ac);
      ctl_t c = '0; c.alusrca = 1; c.alucontrol = ac; return c;
   endfunction
   function automatic ctl_t c_aluwb();
      ctl_t c = '0; c.regwrite = 1; c.regdst = 1; return c;
   endfunction
   function automatic ctl_t c_branch(input logic pe);
      ctl_t c = '0; c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = pe; return c;
   endfunction
   function automatic ctl_t c_iexec(input logic [2:0] ac, input logic ze);
      ctl_t c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = ac; c.zeroext = ze; return c;
   endfunction
   function automatic ctl_t c_iwb(input logic ze);
      ctl_t c = '0; c.regwrite = 1; c.zeroext = ze; return c;
   endfunction
   function automatic ctl_t c_jump();
      ctl_t c = '0; c.pcsrc = 2'b10; c.pcen = 1; return c;
   endfunction

   function automatic logic [3:0] rfunc(input logic [5:0] f);
      case (f)
         6'h20:   return 4'b1010;
         6'h22:   return 4'b1110;
         6'h24:   return 4'b1000;
         6'h25:   return 4'b1001;
         6'h2a:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic step(input string tag, input logic m, input ctl_t v);
      exp_t e;
      @(posedge clk); #1;
      mr = m;
      e.tag = tag; e.v = v;
      sbq.push_back(e);
   endtask

   task automatic check_instret(input string tag);
      logic [31:0] want;
      @(posedge clk); #1;
      mr = 1'b0;
      @(negedge clk);
      want = (sel == 2) ? (exp_cnt[2] & 15) : exp_cnt[sel];
      check_eq(tag, cnt_obs, want);
   endtask

   // one instruction: w wait cycles on each memory access; ext tells whether the selected DUT has EXT_OPS
   task automatic run(input string name, input logic [5:0] o, input logic [5:0] f, input logic z,
                      input int w, input logic ext);
      logic [3:0] rf;
      op = o; funct = f; zero = z;
      rf = rfunc(f);
      for (int i = 0; i < w; i++) step({name, "_fwait"}, 1'b0, c_fetch(1'b0));
      step({name, "_fetch"}, 1'b1, c_fetch(1'b1));
      case (o)
         6'b100011: begin
            step({name, "_dec"}, 1'b0, c_decode(1'b0));
            step({name, "_adr"}, 1'b0, c_memadr());
            for (int i = 0; i < w; i++) step({name, "_rdwait"}, 1'b0, c_memrd());
            step({name, "_rd"}, 1'b1, c_memrd());
            step({name, "_wb"}, 1'b0, c_memwb());
            exp_cnt[sel]++;
         end
         6'b101011: begin
            step({name, "_dec"}, 1'b0, c_decode(1'b0));
            step({name, "_adr"}, 1'b0, c_memadr());
            for (int i = 0; i < w; i++) step({name, "_wrwait"}, 1'b0, c_memwr());
            step({name, "_wr"}, 1'b1, c_memwr());
            exp_cnt[sel]++;
         end
         6'b000000: begin
            if (rf[3]) begin
               step({name, "_dec"}, 1'b0, c_decode(1'b0));
               step({name, "_exec"}, 1'b0, c_exec(rf[2:0]));
               step({name, "_wb"}, 1'b0, c_aluwb());
               exp_cnt[sel]++;
            end else step({name, "_ill"}, 1'b0, c_decode(1'b1));
         end
         6'b000100: begin
            step({name, "_dec"}, 1'b0, c_decode(1'b0));
            step({name, "_br"}, 1'b0, c_branch(z));
            exp_cnt[sel]++;
         end
         6'b000101, 6'b001000, 6'b001100, 6'b001101, 6'b000010: begin
            if (!ext) step({name, "_ill"}, 1'b0, c_decode(1'b1));
            else begin
               step({name, "_dec"}, 1'b0, c_decode(1'b0));
               if (o == 6'b000101) step({name, "_br"}, 1'b0, c_branch(!z));
               else if (o == 6'b000010) step({name, "_jmp"}, 1'b0, c_jump());
               else begin
                  step({name, "_iex"}, 1'b0, c_iexec((o == 6'b001100) ? 3'b000 :
                                                     (o == 6'b001101) ? 3'b001 : 3'b010,
                                                     o != 6'b001000));
                  step({name, "_iwb"}, 1'b0, c_iwb(o != 6'b001000));
               end
               exp_cnt[sel]++;
            end
         end
         default: step({name, "_ill"}, 1'b0, c_decode(1'b1));
      endcase
      check_instret({name, "_instret"});
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      #2;
      check_eq("rst_memreq",  {31'b0, if_main.memreq},  32'd0);
      check_eq("rst_irwrite", {31'b0, if_main.IRwrite}, 32'd0);
      check_eq("rst_pcen",    {31'b0, if_main.pcEn},    32'd0);
      check_eq("rst_instret", if_main.instret,          32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      sel = 0;
      run("add",  6'b000000, 6'h20, 1'b0, 0, 1'b1);
      run("lw",   6'b100011, 6'h00, 1'b0, 3, 1'b1);
      run("beq",  6'b000100, 6'h00, 1'b1, 0, 1'b1);
      run("bne",  6'b000101, 6'h00, 1'b1, 0, 1'b1);
      run("ori",  6'b001101, 6'h00, 1'b0, 0, 1'b1);
      run("sw",   6'b101011, 6'h00, 1'b0, 1, 1'b1);
      run("andi", 6'b001100, 6'h00, 1'b0, 2, 1'b1);
      run("addi", 6'b001000, 6'h00, 1'b0, 0, 1'b1);
      run("sub",  6'b000000, 6'h22, 1'b0, 2, 1'b1);
      run("slt",  6'b000000, 6'h2a, 1'b0, 0, 1'b1);
      run("or",   6'b000000, 6'h25, 1'b0, 0, 1'b1);
      run("and",  6'b000000, 6'h24, 1'b0, 1, 1'b1);
      run("badf", 6'b000000, 6'h00, 1'b0, 0, 1'b1);
      run("badop",6'b111111, 6'h00, 1'b0, 1, 1'b1);
      run("j",    6'b000010, 6'h00, 1'b0, 0, 1'b1);
      run("beq0", 6'b000100, 6'h00, 1'b0, 0, 1'b1);
      run("bne0", 6'b000101, 6'h00, 1'b0, 0, 1'b1);

      // reset in the middle of a stalled store
      op = 6'b101011;
      step("swr_fetch", 1'b1, c_fetch(1'b1));
      step("swr_dec",   1'b0, c_decode(1'b0));
      step("swr_adr",   1'b0, c_memadr());
      for (int i = 0; i < 5; i++) step("swr_wait", 1'b0, c_memwr());
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_eq("abort_memreq",   {31'b0, if_main.memreq},   32'd0);
      check_eq("abort_memwrite", {31'b0, if_main.memwrite}, 32'd0);
      @(negedge clk);
      check_eq("abort_instret", if_main.instret, 32'd0);
      exp_cnt = '{0, 0, 0};
      @(posedge clk); #1;
      rst = 1'b0;
      step("post_rst_fetch", 1'b0, c_fetch(1'b0));
      run("post_add", 6'b000000, 6'h20, 1'b0, 0, 1'b1);

      sel = 1;
      run("nx_ori", 6'b001101, 6'h00, 1'b0, 0, 1'b0);
      run("nx_j",   6'b000010, 6'h00, 1'b0, 1, 1'b0);
      run("nx_bne", 6'b000101, 6'h00, 1'b0, 0, 1'b0);
      run("nx_add", 6'b000000, 6'h20, 1'b0, 0, 1'b0);

      sel = 2;
      for (int i = 0; i < 17; i++) run("w4_j", 6'b000010, 6'h00, 1'b0, 0, 1'b1);
      check_eq("w4_wrap", {28'b0, if_w4.instret}, 32'd1);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle MIPS control unit with a ready/request memory handshake, replacing the fixed single-cycle-memory controller in the multicycle core. It sequences fetch, decode, execute, memory and writeback states. It stalls any number of cycles on a slow memory and optionally supports an extended instruction set. It also keeps a retired-instruction counter. It sits beside the datapath in the `mips` top and drives all datapath strobes and selects.

## Interface
- `EXT_OPS`, default 1: enables addi, andi, ori, bne and j. When 0, these opcodes decode as illegal.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  : system clock, rising edge.
- `reset`  in  1  : asynchronous, active-high reset.
- `op`  in  6  : instr[31:26].
- `funct`  in  6  : instr[5:0].
- `zero`  in  1  : ALU zero flag.
- `memready`  in  1  : memory completes the current access this cycle.
- `memreq`  out  1  : memory access request.
- `memwrite`  out  1  : write access; valid only with `memreq`.
- `IorD`, `IRwrite`, `memtoreg`, `pcEn`, `regwrite`, `regdst`, `alusrcA`  out  1 each  : datapath controls.
- `zeroext`  out  1  : immediate is zero-extended instead of sign-extended.
- `alucontrol`  out  3  : 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `alusrcB`  out  2  : 00 B, 01 constant 4, 10 signimm, 11 signimm<<2.
- `pcsrc`  out  2  : 00 ALU result, 01 aluout, 10 jump target.
- `illegal`  out  1  : one-cycle pulse on an undecodable instruction.
- `instret`  out  CNT_W  : count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IEXEC, IWB, JUMP. Outputs are Moore, except the `memready`-qualified strobes listed below.
- FETCH
  - Outputs: `memreq`=1, IorD=0, alusrcA=0, alusrcB=01, alucontrol=010, pcsrc=00.
  - IRwrite and pcEn assert only in a cycle where `memready`=1, and the state then advances to DECODE. Otherwise the state holds in FETCH.
- DECODE
  - Outputs: alusrcA=0, alusrcB=11, alucontrol=010 (branch target into aluout).
  - Next state by op: lw/sw→MEMADR, R→EXEC, beq/bne→BRANCH, addi/andi/ori→IEXEC, j→JUMP.
  - Any other op, an R-type funct other than add/sub/and/or/slt, or an extended op with EXT_OPS=0: `illegal`=1 for this cycle, next state FETCH, no writes.
- MEMADR
  - Outputs: alusrcA=1, alusrcB=10, alucontrol=010.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD
  - Outputs: `memreq`=1, IorD=1.
  - Holds until `memready`, then goes to MEMWB.
- MEMWB
  - Outputs: regwrite=1, memtoreg=1, regdst=0.
  - Next state FETCH.
- MEMWR
  - Outputs: `memreq`=1, `memwrite`=1, IorD=1.
  - Holds until `memready`, then goes to FETCH.
- EXEC
  - Outputs: alusrcA=1, alusrcB=00, alucontrol from funct.
  - Next state ALUWB.
- ALUWB
  - Outputs: regwrite=1, regdst=1, memtoreg=0.
- BRANCH
  - Outputs: alusrcA=1, alusrcB=00, alucontrol=110, pcsrc=01.
  - pcEn = (beq & zero) | (bne & ~zero).
- IEXEC
  - Outputs: alusrcA=1, alusrcB=10.
  - alucontrol: 010 for addi, 000 for andi, 001 for ori.
  - zeroext=1 for andi/ori.
- IWB
  - Outputs: regwrite=1, regdst=0, memtoreg=0.
  - zeroext is held at its IEXEC value.
- JUMP
  - Outputs: pcsrc=10, pcEn=1.
- ALUWB, BRANCH, IWB and JUMP all return to FETCH.
- Any output not listed for a state is 0.
- `instret` increments by 1 on the final cycle of each legal instruction: MEMWB, ALUWB, IWB, BRANCH, JUMP, and MEMWR when `memready`=1.
  - It wraps modulo 2^CNT_W.
  - Illegal instructions do not count.

## Timing
- Reset
  - State goes to FETCH and `instret` to 0, asynchronously.
  - While `reset`=1, `memreq`, `memwrite`, IRwrite, pcEn, regwrite and `illegal` are forced to 0.
  - The first request is made in the first cycle after reset deasserts.
- W is the number of wait cycles per memory access, i.e. cycles with `memreq`=1 and `memready`=0.
- Latency in cycles:
  - lw: 5+2W
  - sw: 4+2W
  - R-type, addi/andi/ori: 4+W
  - beq, bne, j: 3+W
  - illegal: 2+W
- Handshake
  - `memready` is ignored when `memreq`=0.
  - `memreq` and `memwrite` remain stable until the completing cycle.
- Reset mid-access aborts the access; no strobe is issued.

## Structure
- Shared package `mips_pkg`: state enum, opcode and funct constants, alucontrol, alusrcB and pcsrc encodings.
- Sub-module `alu_decoder`: combinational funct→alucontrol mapping plus a funct-valid flag, instantiated once.

## Test plan
- R-type add (funct 100000), `memready` tied high → ALUWB (regwrite=1, regdst=1) in cycle 4; `instret` 0→1.
- lw with `memready` low for 3 cycles on each access → 11 cycles total; `memreq` held through every wait; MEMWB has memtoreg=1.
- beq followed by bne, with `zero`=1 in both BRANCH cycles → pcEn=1 for beq, pcEn=0 for bne; `instret` +2.
- ori (op 001101) → IEXEC has zeroext=1, alucontrol=001; repeat with EXT_OPS=0 → `illegal` pulses, no regwrite, `instret` unchanged.
- Reset asserted during a 5-cycle MEMWR stall → `memreq`/`memwrite` drop immediately; after release, state is FETCH and `instret` is 0.
- CNT_W=4, 17 retired j instructions → `instret` wraps to 1.
